pll_reconf_seq: RTL and testbench

Consumer end of the button controller's PLL-change interface. It accepts a one-cycle `PLL_CHG` pulse carrying an 8-bit `PLL_ADDR`, then streams the matching scan-chain image from an external 1-bit-wide configuration ROM into the PLL reconfiguration port. It issues the config-update pulse and resets the PLL, then waits for lock. The block sits between the button/control logic and the PLL macro, and busy/error status goes back to the control side.

---
 rtl/pll_reconf_seq_pkg.sv | 23 ++
 rtl/pll_reconf_seq_scan_shift.sv | 71 +++++++
 rtl/pll_reconf_seq.sv | 150 +++++++++++++++
 tb/tb_pll_reconf_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconf_seq_pkg.sv
// Shared types and default parameters for the PLL reconfiguration sequencer.
package pll_reconf_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StUpdate,
        StWaitDone,
        StPreset,
        StWaitLock
    } state_t;

    localparam int unsigned DefScanLen = 144;
    localparam int unsigned DefIw      = 8;
    localparam int unsigned DefToCyc   = 20000;
    localparam int unsigned DefRstCyc  = 16;

    // Counter width wide enough to hold the larger of the two cycle limits.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/pll_reconf_seq_scan_shift.sv
// Scan-chain shifter: walks ROM bits 0..SCAN_LEN-1 and drives the PLL scan port at CLK/2.
module pll_reconf_seq_scan_shift
    import pll_reconf_seq_pkg::*;
#(
    parameter int unsigned SCAN_LEN = DefScanLen,
    parameter int unsigned IW       = DefIw
) (
    input  logic            CLK,
    input  logic            RSTX,
    input  logic            start,
    input  logic [7:0]      start_addr,
    output logic [8+IW-1:0] rom_addr,
    input  logic            rom_data,
    output logic            scanclk,
    output logic            scanclkena,
    output logic            scandata,
    output logic            done
);

    localparam logic [IW-1:0] LastIdx = IW'(SCAN_LEN - 1);

    logic          active_q;
    logic          phase_h_q;  // next edge is the SCANCLK rising phase
    logic          last_q;     // final bit has been clocked into the PLL
    logic [IW-1:0] idx_q;

    // Two-phase shift engine; the ROM address runs one bit ahead of SCANDATA.
    always_ff @(posedge CLK) begin
        if (!RSTX) begin
            active_q   <= 1'b0;
            phase_h_q  <= 1'b0;
            last_q     <= 1'b0;
            idx_q      <= '0;
            rom_addr   <= '0;
            scanclk    <= 1'b0;
            scanclkena <= 1'b0;
            scandata   <= 1'b0;
        end else if (start) begin
            active_q   <= 1'b1;
            phase_h_q  <= 1'b0;
            last_q     <= 1'b0;
            idx_q      <= '0;
            rom_addr   <= {start_addr, {IW{1'b0}}};
            scanclk    <= 1'b0;
            scanclkena <= 1'b1;
        end else if (active_q) begin
            if (phase_h_q) begin
                scanclk   <= 1'b1;
                phase_h_q <= 1'b0;
                if (idx_q == LastIdx) begin
                    last_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end else if (last_q) begin
                scanclk    <= 1'b0;
                scanclkena <= 1'b0;
                active_q   <= 1'b0;
            end else begin
                scandata           <= rom_data;
                scanclk            <= 1'b0;
                phase_h_q          <= 1'b1;
                rom_addr[IW-1:0]   <= (idx_q == LastIdx) ? idx_q : idx_q + 1'b1;
            end
        end
    end

    // High during the cycle before the closing low phase, so the FSM can pulse update on it.
    assign done = active_q & ~phase_h_q & last_q;

endmodule

// File: rtl/pll_reconf_seq.sv
// PLL reconfiguration sequencer: load scan image, update, reset PLL, wait for lock.
module pll_reconf_seq
    import pll_reconf_seq_pkg::*;
#(
    parameter int unsigned SCAN_LEN = DefScanLen,
    parameter int unsigned IW       = DefIw,
    parameter int unsigned TO_CYC   = DefToCyc,
    parameter int unsigned RST_CYC  = DefRstCyc
) (
    input  logic            CLK,
    input  logic            RSTX,
    input  logic            PLL_CHG,
    input  logic [7:0]      PLL_ADDR,
    output logic [8+IW-1:0] ROM_ADDR,
    input  logic            ROM_DATA,
    output logic            SCANCLK,
    output logic            SCANCLKENA,
    output logic            SCANDATA,
    output logic            CONFIGUPDATE,
    input  logic            SCANDONE,
    input  logic            LOCKED,
    output logic            PLL_ARESET,
    output logic            BUSY,
    output logic            ERR
);

    localparam int unsigned CW = cnt_width(TO_CYC, RST_CYC);

    state_t       state_q;
    logic [CW-1:0] cnt_q;
    logic         pend_q;
    logic [7:0]   pend_addr_q;
    logic         start;
    logic [7:0]   start_addr;
    logic         scan_done;
    logic         to_hit;

    // A queued request always wins over a fresh strobe when leaving IDLE.
    always_comb begin
        start      = (state_q == StIdle) && (pend_q || PLL_CHG);
        start_addr = pend_q ? pend_addr_q : PLL_ADDR;
        to_hit     = (cnt_q == CW'(TO_CYC - 1));
    end

    // Sequencer FSM with shared wait counter, pending-request capture and status outputs.
    always_ff @(posedge CLK) begin
        if (!RSTX) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            CONFIGUPDATE <= 1'b0;
            PLL_ARESET   <= 1'b0;
            BUSY         <= 1'b0;
            ERR          <= 1'b0;
        end else begin
            if (state_q != StIdle) begin
                if (PLL_CHG) begin
                    pend_q      <= 1'b1;
                    pend_addr_q <= PLL_ADDR;
                end
            end else if (pend_q) begin
                // Pending request is consumed now; a coincident strobe queues behind it.
                pend_q <= PLL_CHG;
                if (PLL_CHG) begin
                    pend_addr_q <= PLL_ADDR;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StLoad;
                        BUSY    <= 1'b1;
                        ERR     <= 1'b0;
                    end
                end
                StLoad: begin
                    if (scan_done) begin
                        state_q      <= StUpdate;
                        CONFIGUPDATE <= 1'b1;
                    end
                end
                StUpdate: begin
                    CONFIGUPDATE <= 1'b0;
                    state_q      <= StWaitDone;
                    cnt_q        <= '0;
                end
                StWaitDone: begin
                    if (SCANDONE) begin
                        state_q    <= StPreset;
                        PLL_ARESET <= 1'b1;
                        cnt_q      <= '0;
                    end else if (to_hit) begin
                        state_q <= StIdle;
                        ERR     <= 1'b1;
                        BUSY    <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPreset: begin
                    if (cnt_q == CW'(RST_CYC - 1)) begin
                        state_q    <= StWaitLock;
                        PLL_ARESET <= 1'b0;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitLock: begin
                    if (LOCKED) begin
                        state_q <= StIdle;
                        BUSY    <= 1'b0;
                        cnt_q   <= '0;
                    end else if (to_hit) begin
                        state_q <= StIdle;
                        ERR     <= 1'b1;
                        BUSY    <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

    pll_reconf_seq_scan_shift #(
        .SCAN_LEN (SCAN_LEN),
        .IW       (IW)
    ) u_scan_shift (
        .CLK        (CLK),
        .RSTX       (RSTX),
        .start      (start),
        .start_addr (start_addr),
        .rom_addr   (ROM_ADDR),
        .rom_data   (ROM_DATA),
        .scanclk    (SCANCLK),
        .scanclkena (SCANCLKENA),
        .scandata   (SCANDATA),
        .done       (scan_done)
    );

endmodule

// File: tb/tb_pll_reconf_seq.sv
// Scoreboard bench for pll_reconf_seq: expected output events carry the edge they must occur on.
module tb_pll_reconf_seq;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned TO = 50;
    localparam int unsigned RC = 16;

    localparam int EvBusyOn  = 0;
    localparam int EvErrOff  = 1;
    localparam int EvBit     = 2;
    localparam int EvEnaOff  = 3;
    localparam int EvCfgOn   = 4;
    localparam int EvCfgOff  = 5;
    localparam int EvRstOn   = 6;
    localparam int EvRstOff  = 7;
    localparam int EvErrOn   = 8;
    localparam int EvBusyOff = 9;

    logic            CLK = 1'b0;
    logic            RSTX = 1'b0;
    logic            PLL_CHG = 1'b0;
    logic [7:0]      PLL_ADDR = 8'h00;
    logic [8+IW-1:0] ROM_ADDR;
    logic            ROM_DATA;
    logic            SCANCLK;
    logic            SCANCLKENA;
    logic            SCANDATA;
    logic            CONFIGUPDATE;
    logic            SCANDONE = 1'b0;
    logic            LOCKED = 1'b0;
    logic            PLL_ARESET;
    logic            BUSY;
    logic            ERR;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int kind;
        int value;
        int cyc;
    } ev_t;

    ev_t exp_q[$];

    pll_reconf_seq #(
        .SCAN_LEN (N),
        .IW       (IW),
        .TO_CYC   (TO),
        .RST_CYC  (RC)
    ) dut (
        .CLK          (CLK),
        .RSTX         (RSTX),
        .PLL_CHG      (PLL_CHG),
        .PLL_ADDR     (PLL_ADDR),
        .ROM_ADDR     (ROM_ADDR),
        .ROM_DATA     (ROM_DATA),
        .SCANCLK      (SCANCLK),
        .SCANCLKENA   (SCANCLKENA),
        .SCANDATA     (SCANDATA),
        .CONFIGUPDATE (CONFIGUPDATE),
        .SCANDONE     (SCANDONE),
        .LOCKED       (LOCKED),
        .PLL_ARESET   (PLL_ARESET),
        .BUSY         (BUSY),
        .ERR          (ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // ROM model: each bit is the parity of its address.
    assign ROM_DATA = ^ROM_ADDR;

    function automatic int par(input int a, input int k);
        logic [8+IW-1:0] v;
        v = {a[7:0], k[IW-1:0]};
        return (^v) ? 1 : 0;
    endfunction

    task automatic push(input int kind, input int value, input int c);
        ev_t e;
        e.kind  = kind;
        e.value = value;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    task automatic push_load(input int a, input int e0, input bit clr_err);
        push(EvBusyOn, a * (1 << IW), e0);
        if (clr_err) push(EvErrOff, 0, e0);
        for (int k = 0; k < int'(N); k++) push(EvBit, par(a, k), e0 + 2 * k + 2);
        push(EvEnaOff, 0, e0 + 2 * N + 1);
        push(EvCfgOn, 0, e0 + 2 * N + 1);
        push(EvCfgOff, 0, e0 + 2 * N + 2);
    endtask

    task automatic push_tail(input int d, input int l);
        push(EvRstOn, 0, d);
        push(EvRstOff, 0, d + RC);
        push(EvBusyOff, 0, l);
    endtask

    task automatic got(input int kind, input int value);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual kind=%0d value=%0d cyc=%0d required none",
                     kind, value, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.value != value || e.cyc != cyc) begin
                failures++;
                $display("FAIL event actual kind=%0d value=%0d cyc=%0d required kind=%0d value=%0d cyc=%0d",
                         kind, value, cyc, e.kind, e.value, e.cyc);
            end
        end
    endtask

    logic p_busy = 1'b0, p_err = 1'b0, p_sclk = 1'b0, p_ena = 1'b0, p_cfg = 1'b0, p_rst = 1'b0;

    // Monitor: turn output transitions into events, in a fixed per-edge order.
    always @(negedge CLK) begin
        if (!p_busy && BUSY === 1'b1) got(EvBusyOn, int'(ROM_ADDR));
        if (p_err && ERR === 1'b0) got(EvErrOff, 0);
        if (!p_sclk && SCANCLK === 1'b1) got(EvBit, int'(SCANDATA));
        if (p_ena && SCANCLKENA === 1'b0) got(EvEnaOff, 0);
        if (!p_cfg && CONFIGUPDATE === 1'b1) got(EvCfgOn, 0);
        if (p_cfg && CONFIGUPDATE === 1'b0) got(EvCfgOff, 0);
        if (!p_rst && PLL_ARESET === 1'b1) got(EvRstOn, 0);
        if (p_rst && PLL_ARESET === 1'b0) got(EvRstOff, 0);
        if (!p_err && ERR === 1'b1) got(EvErrOn, 0);
        if (p_busy && BUSY === 1'b0) got(EvBusyOff, 0);
        p_busy <= (BUSY === 1'b1);
        p_err  <= (ERR === 1'b1);
        p_sclk <= (SCANCLK === 1'b1);
        p_ena  <= (SCANCLKENA === 1'b1);
        p_cfg  <= (CONFIGUPDATE === 1'b1);
        p_rst  <= (PLL_ARESET === 1'b1);
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Advance to the negedge just before edge e, so inputs driven now are sampled at e.
    task automatic goto(input int e);
        while (cyc < e - 1) @(negedge CLK);
    endtask

    task automatic pulse_chg(input int a, input int e);
        goto(e);
        PLL_CHG  = 1'b1;
        PLL_ADDR = 8'(a);
        @(negedge CLK);
        PLL_CHG  = 1'b0;
    endtask

    task automatic pulse_done(input int e);
        goto(e);
        SCANDONE = 1'b1;
        @(negedge CLK);
        SCANDONE = 1'b0;
    endtask

    task automatic pulse_lock(input int e);
        goto(e);
        LOCKED = 1'b1;
        @(negedge CLK);
        LOCKED = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, d, l, e1, d1, l1, t;
        logic [8+IW+6:0] outs;

        // Reset
        RSTX = 1'b0;
        repeat (3) @(negedge CLK);
        outs = {ROM_ADDR, SCANCLK, SCANCLKENA, SCANDATA, CONFIGUPDATE, PLL_ARESET, BUSY, ERR};
        check("reset_outputs_known", int'($isunknown(outs)), 0);
        check("reset_outputs_zero", int'(outs), 0);
        RSTX = 1'b1;
        repeat (2) @(negedge CLK);
        check("busy_after_release", int'(BUSY), 0);

        // Basic load at address 0x05
        e0 = cyc + 2;
        d  = e0 + 2 * N + 2 + 3;
        l  = d + RC + 4;
        push_load(5, e0, 1'b0);
        push_tail(d, l);
        pulse_chg(5, e0);
        pulse_done(d);
        pulse_lock(l);
        goto(l + 3);

        // Pending: 0x02 runs, 0x03 overwritten by 0x04, which runs next
        e0 = cyc + 2;
        d  = e0 + 2 * N + 2 + 3;
        l  = d + RC + 4;
        e1 = l + 1;
        d1 = e1 + 2 * N + 2 + 3;
        l1 = d1 + RC + 4;
        push_load(2, e0, 1'b0);
        push_tail(d, l);
        push_load(4, e1, 1'b0);
        push_tail(d1, l1);
        pulse_chg(2, e0);
        pulse_chg(3, e0 + 4);
        pulse_chg(4, e0 + 8);
        pulse_done(d);
        pulse_lock(l);
        pulse_done(d1);
        pulse_lock(l1);
        goto(l1 + 3);

        // Timeout in WAIT_DONE, then a new request clears ERR
        e0 = cyc + 2;
        t  = e0 + 2 * N + 2 + TO;
        push_load(9, e0, 1'b0);
        push(EvErrOn, 0, t);
        push(EvBusyOff, 0, t);
        pulse_chg(9, e0);
        goto(t + 2);
        check("err_after_timeout", int'(ERR), 1);
        check("areset_after_timeout", int'(PLL_ARESET), 0);
        e0 = cyc + 2;
        d  = e0 + 2 * N + 2 + 3;
        l  = d + RC + 4;
        push_load(1, e0, 1'b1);
        push_tail(d, l);
        pulse_chg(1, e0);
        pulse_done(d);
        pulse_lock(l);
        goto(l + 3);
        check("err_cleared_by_new_load", int'(ERR), 0);

        // Collision: request 0x07 on the same edge LOCKED ends a sequence
        e0 = cyc + 2;
        d  = e0 + 2 * N + 2 + 3;
        l  = d + RC + 4;
        e1 = l + 1;
        d1 = e1 + 2 * N + 2 + 3;
        l1 = d1 + RC + 4;
        push_load(8'h0B, e0, 1'b0);
        push_tail(d, l);
        push_load(7, e1, 1'b0);
        push_tail(d1, l1);
        pulse_chg(8'h0B, e0);
        pulse_done(d);
        goto(l);
        LOCKED   = 1'b1;
        PLL_CHG  = 1'b1;
        PLL_ADDR = 8'h07;
        @(negedge CLK);
        LOCKED   = 1'b0;
        PLL_CHG  = 1'b0;
        pulse_done(d1);
        pulse_lock(l1);
        goto(l1 + 3);

        // Mid-LOAD reset at bit 3 discards the pending request
        e0 = cyc + 2;
        push(EvBusyOn, 6 * (1 << IW), e0);
        for (int k = 0; k < 3; k++) push(EvBit, par(6, k), e0 + 2 * k + 2);
        push(EvEnaOff, 0, e0 + 7);
        push(EvBusyOff, 0, e0 + 7);
        pulse_chg(6, e0);
        pulse_chg(8'h0A, e0 + 3);
        goto(e0 + 7);
        RSTX = 1'b0;
        repeat (2) @(negedge CLK);
        RSTX = 1'b1;
        goto(e0 + 90);
        check("busy_after_midload_reset", int'(BUSY), 0);
        check("ena_after_midload_reset", int'(SCANCLKENA), 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
